// File: rtl/xbus_lsu.sv
// Load/store unit bridging the core memory stage to the xbus with req/ack handshake.
// Optional macro XBUS_LSU_MISALIGN_SPLIT_EN enables two-beat misaligned accesses.
module xbus_lsu #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [XLEN-1:0]   rdata,
    output logic              xbus_req,
    output logic              xbus_we,
    output logic [XLEN/8-1:0] xbus_be,
    output logic [31:0]       xbus_addr,
    output logic [XLEN-1:0]   xbus_wdata,
    input  logic [XLEN-1:0]   xbus_rdata,
    input  logic              xbus_ack
);
    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam logic [2*BW-1:0] L_ONE = {{(2*BW-1){1'b0}}, 1'b1};
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
    localparam logic L_SPLIT_EN = 1'b1;
`else
    localparam logic L_SPLIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP, S_ERR} state_t;

    state_t r_state, w_state_nx;

    logic            r_req_ready, r_resp_valid, r_resp_err, r_xbus_req, r_xbus_we;
    logic [BW-1:0]   r_xbus_be;
    logic [31:0]     r_xbus_addr;
    logic [XLEN-1:0] r_xbus_wdata, r_rdata;
    logic            r_we, r_uns;
    logic [1:0]      r_size;
    logic [OW-1:0]   r_off;

    logic            w_req_nx, w_we_nx, w_resp_valid_nx, w_resp_err_nx, w_accept, w_last_beat;
    logic [BW-1:0]   w_be_nx, w_be0, w_be1;
    logic [31:0]     w_addr_nx;
    logic [XLEN-1:0] w_wd_nx, w_rdata_nx, w_wd0, w_wd1, w_raw, w_load;
    logic [3:0]      w_size_b;
    logic [OW-1:0]   w_off;
    logic            w_split, w_err;
    logic [2*BW-1:0] w_smask;

    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] raw,
                                                 input logic [1:0] size, input logic uns);
        logic [XLEN-1:0] mask;
        logic            msb;
        case (size)
            2'b00:   begin mask = XLEN'(8'hFF);          msb = raw[7];      end
            2'b01:   begin mask = XLEN'(16'hFFFF);       msb = raw[15];     end
            2'b10:   begin mask = XLEN'(32'hFFFF_FFFF);  msb = raw[31];     end
            default: begin mask = {XLEN{1'b1}};          msb = raw[XLEN-1]; end
        endcase
        if (uns || !msb) f_extend = raw & mask;
        else             f_extend = raw | ~mask;
    endfunction

    assign w_size_b = 4'd1 << funct3[1:0];
    assign w_off    = addr[OW-1:0];
    assign w_split  = (5'(w_off) + 5'(w_size_b)) > 5'(BW);
    assign w_err    = ((funct3[1:0] == 2'b11) && (XLEN == 32)) || (w_split && !L_SPLIT_EN);
    assign w_smask  = (L_ONE << w_size_b) - L_ONE;
    assign w_be0    = BW'(w_smask << w_off);
    assign w_wd0    = wdata << {w_off, 3'b000};

`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
    logic            r_split;
    logic [BW-1:0]   r_be1;
    logic [XLEN-1:0] r_wdata1, r_rd0;
    logic [XLEN-1:0] w_hi, w_lo;

    assign w_be1       = BW'(w_smask >> (32'(BW) - 32'(w_off)));
    assign w_wd1       = wdata >> ((32'(BW) - 32'(w_off)) << 3);
    assign w_last_beat = (r_state == S_BEAT1) || !r_split;
    // Second-beat data sits above the first so one shift realigns a split load.
    assign w_hi        = (r_state == S_BEAT1) ? xbus_rdata : {XLEN{1'b0}};
    assign w_lo        = (r_state == S_BEAT1) ? r_rd0 : xbus_rdata;
    assign w_raw       = XLEN'({w_hi, w_lo} >> {r_off, 3'b000});

    // Split bookkeeping: beat-1 lanes at acceptance, beat-0 read data on its ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_split  <= 1'b0;
            r_be1    <= {BW{1'b0}};
            r_wdata1 <= {XLEN{1'b0}};
            r_rd0    <= {XLEN{1'b0}};
        end else begin
            if (w_accept) begin
                r_split  <= w_split;
                r_be1    <= w_be1;
                r_wdata1 <= w_wd1;
            end
            if ((r_state == S_BEAT0) && xbus_ack) r_rd0 <= xbus_rdata;
        end
    end
`else
    assign w_be1       = {BW{1'b0}};
    assign w_wd1       = {XLEN{1'b0}};
    assign w_last_beat = 1'b1;
    assign w_raw       = xbus_rdata >> {r_off, 3'b000};
`endif

    assign w_load = r_we ? {XLEN{1'b0}} : f_extend(w_raw, r_size, r_uns);

    // Next state and next values of every registered output
    always_comb begin
        w_state_nx      = r_state;
        w_req_nx        = r_xbus_req;
        w_we_nx         = r_xbus_we;
        w_be_nx         = r_xbus_be;
        w_addr_nx       = r_xbus_addr;
        w_wd_nx         = r_xbus_wdata;
        w_resp_valid_nx = 1'b0;
        w_resp_err_nx   = 1'b0;
        w_rdata_nx      = {XLEN{1'b0}};
        w_accept        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_err) begin
                        w_state_nx      = S_ERR;
                        w_resp_valid_nx = 1'b1;
                        w_resp_err_nx   = 1'b1;
                    end else begin
                        w_state_nx = S_BEAT0;
                        w_req_nx   = 1'b1;
                        w_we_nx    = req_we;
                        w_addr_nx  = {addr[31:OW], {OW{1'b0}}};
                        w_be_nx    = w_be0;
                        w_wd_nx    = w_wd0;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
            S_BEAT0, S_BEAT1: begin
`else
            S_BEAT0: begin
`endif
                if (!xbus_ack) begin
                    w_state_nx = r_state;
                end else if (w_last_beat) begin
                    w_state_nx      = S_RESP;
                    w_req_nx        = 1'b0;
                    w_we_nx         = 1'b0;
                    w_be_nx         = {BW{1'b0}};
                    w_addr_nx       = 32'h0000_0000;
                    w_wd_nx         = {XLEN{1'b0}};
                    w_resp_valid_nx = 1'b1;
                    w_rdata_nx      = w_load;
                end else begin
                    w_state_nx = S_BEAT1;
                    w_addr_nx  = r_xbus_addr + 32'(BW);
                    w_be_nx    = w_be1;
                    w_wd_nx    = w_wd1;
                end
            end
            S_RESP, S_ERR: w_state_nx = S_IDLE;
            default:       w_state_nx = S_IDLE;
        endcase
    end

    // State, output and request-field registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= {XLEN{1'b0}};
            r_xbus_req   <= 1'b0;
            r_xbus_we    <= 1'b0;
            r_xbus_be    <= {BW{1'b0}};
            r_xbus_addr  <= 32'h0000_0000;
            r_xbus_wdata <= {XLEN{1'b0}};
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= {OW{1'b0}};
        end else begin
            r_state      <= w_state_nx;
            r_req_ready  <= (w_state_nx == S_IDLE);
            r_resp_valid <= w_resp_valid_nx;
            r_resp_err   <= w_resp_err_nx;
            r_rdata      <= w_rdata_nx;
            r_xbus_req   <= w_req_nx;
            r_xbus_we    <= w_we_nx;
            r_xbus_be    <= w_be_nx;
            r_xbus_addr  <= w_addr_nx;
            r_xbus_wdata <= w_wd_nx;
            if (w_accept) begin
                r_we   <= req_we;
                r_uns  <= funct3[2];
                r_size <= funct3[1:0];
                r_off  <= w_off;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign rdata      = r_rdata;
    assign xbus_req   = r_xbus_req;
    assign xbus_we    = r_xbus_we;
    assign xbus_be    = r_xbus_be;
    assign xbus_addr  = r_xbus_addr;
    assign xbus_wdata = r_xbus_wdata;
endmodule

// File: tb/tb_xbus_lsu.sv
// Bench for xbus_lsu (XLEN=32): directed vector table, mid-beat reset sequence,
// and random accesses checked against a byte-addressed memory model.
module tb_xbus_lsu;
`ifdef XBUS_LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_we, resp_valid, resp_err;
    logic        xbus_req, xbus_we, xbus_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, xbus_addr, xbus_wdata, xbus_rdata;
    logic [3:0]  xbus_be;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [logic [31:0]];

    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] a; logic [31:0] wd; int waits;
        logic err; int nb; logic [31:0] a0; logic [3:0] be0; logic [31:0] wd0;
        logic [3:0] be1; logic [31:0] wd1; logic [31:0] rd; int lat;
    } vec_t;

    typedef struct {
        logic err; int nbeats; logic [1:0][31:0] ba; logic [1:0][3:0] be;
        logic [1:0][31:0] bwd; logic [31:0] rdata; int lat;
        logic busy_ok; logic stable_ok; logic after_ok;
    } txn_t;

    xbus_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
        .xbus_req(xbus_req), .xbus_we(xbus_we), .xbus_be(xbus_be),
        .xbus_addr(xbus_addr), .xbus_wdata(xbus_wdata),
        .xbus_rdata(xbus_rdata), .xbus_ack(xbus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic void set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
    endfunction

    // Little-endian gather of s bytes from memory, then extension.
    function automatic logic [31:0] model_load(input logic [31:0] a, input int s, input logic uns);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < s; i++) v[8*i +: 8] = byte_at(a + 32'(i));
        if (!uns && v[8*s-1]) for (int i = s; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Lane j of bus word b is enabled iff its byte address lies in [a, a+s).
    function automatic logic [3:0] model_be(input logic [31:0] a, input int s, input int b);
        logic [3:0]  be;
        logic [31:0] base;
        base = (a & 32'hFFFF_FFFC) + 32'(4 * b);
        for (int j = 0; j < 4; j++) be[j] = (base + 32'(j) >= a) && (base + 32'(j) < a + 32'(s));
        return be;
    endfunction

    function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int waits, input logic err, input int nb,
                                 input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                                 input logic [3:0] be1, input logic [31:0] wd1, input logic [31:0] rd,
                                 input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.waits = waits; v.err = err; v.nb = nb;
        v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.be1 = be1; v.wd1 = wd1; v.rd = rd; v.lat = lat;
        return v;
    endfunction

    // Issues one request and plays the bus slave with 'waits' stall cycles per beat.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int waits, output txn_t r);
        int k, wcnt, idx;
        bit in_beat, done;
        r.err = 1'b0; r.nbeats = 0; r.ba = '0; r.be = '0; r.bwd = '0; r.rdata = 32'h0; r.lat = 0;
        r.busy_ok = 1'b1; r.stable_ok = 1'b1; r.after_ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        k = 0; wcnt = 0; idx = 0; in_beat = 1'b0; done = 1'b0;
        while (!done && k < 64) begin
            @(negedge clk);
            k++;
            req_valid  = 1'b0;
            xbus_ack   = 1'b0;
            xbus_rdata = $urandom;
            if (req_ready) r.busy_ok = 1'b0;
            if (resp_valid) begin
                r.err = resp_err; r.rdata = rdata; r.lat = k; done = 1'b1;
            end else if (xbus_req) begin
                if (!in_beat) begin
                    idx = (r.nbeats < 2) ? r.nbeats : 1;
                    r.ba[idx] = xbus_addr; r.be[idx] = xbus_be; r.bwd[idx] = xbus_wdata;
                    r.nbeats++; in_beat = 1'b1; wcnt = 0;
                end else if ({xbus_addr, xbus_be, xbus_wdata} !== {r.ba[idx], r.be[idx], r.bwd[idx]}) begin
                    r.stable_ok = 1'b0;
                end
                if (wcnt == waits) begin
                    xbus_ack = 1'b1;
                    in_beat  = 1'b0;
                    for (int j = 0; j < 4; j++) begin
                        xbus_rdata[8*j +: 8] = byte_at(xbus_addr + 32'(j));
                        if (xbus_we && xbus_be[j]) mem[xbus_addr + 32'(j)] = xbus_wdata[8*j +: 8];
                    end
                end else begin
                    wcnt++;
                end
            end
        end
        @(negedge clk);
        xbus_ack = 1'b0;
        if (resp_valid || !req_ready || xbus_req) r.after_ok = 1'b0;
    endtask

    task automatic check_common(input string tag, input txn_t r, input logic e_err,
                                input int e_nb, input logic [31:0] e_rd, input int e_lat);
        check({tag, "_err"},    32'(r.err), 32'(e_err));
        check({tag, "_nbeats"}, 32'(r.nbeats), 32'(e_nb));
        check({tag, "_rdata"},  r.rdata, e_rd);
        check({tag, "_lat"},    32'(r.lat), 32'(e_lat));
        check({tag, "_busy"},   32'(r.busy_ok), 32'h1);
        check({tag, "_stable"}, 32'(r.stable_ok), 32'h1);
        check({tag, "_after"},  32'(r.after_ok), 32'h1);
    endtask

    vec_t vt [12];
    txn_t r;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; xbus_ack = 1'b0; xbus_rdata = 32'h0;
        set_word(32'h1000, 32'hDEAD_BEEF);
        set_word(32'h2000, 32'h8012_3456);
        set_word(32'h4000, 32'h5566_1122);
        set_word(32'h4004, 32'h9900_7788);

        vt[0]  = mkv(1'b0, 3'b010, 32'h1000, 32'h0, 0, 1'b0, 1, 32'h1000, 4'hF, 32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF, 2);
        vt[1]  = mkv(1'b0, 3'b000, 32'h2003, 32'h0, 0, 1'b0, 1, 32'h2000, 4'h8, 32'h0, 4'h0, 32'h0, 32'hFFFF_FF80, 2);
        vt[2]  = mkv(1'b0, 3'b100, 32'h2003, 32'h0, 0, 1'b0, 1, 32'h2000, 4'h8, 32'h0, 4'h0, 32'h0, 32'h0000_0080, 2);
        vt[3]  = mkv(1'b0, 3'b001, 32'h1002, 32'h0, 0, 1'b0, 1, 32'h1000, 4'hC, 32'h0, 4'h0, 32'h0, 32'hFFFF_DEAD, 2);
        vt[4]  = mkv(1'b0, 3'b101, 32'h1002, 32'h0, 1, 1'b0, 1, 32'h1000, 4'hC, 32'h0, 4'h0, 32'h0, 32'h0000_DEAD, 3);
        vt[5]  = mkv(1'b1, 3'b000, 32'h5001, 32'h1234_5678, 0, 1'b0, 1, 32'h5000, 4'h2, 32'h3456_7800, 4'h0, 32'h0, 32'h0, 2);
        vt[6]  = mkv(1'b1, 3'b010, 32'h6000, 32'hCAFE_F00D, 2, 1'b0, 1, 32'h6000, 4'hF, 32'hCAFE_F00D, 4'h0, 32'h0, 32'h0, 4);
        vt[7]  = mkv(1'b0, 3'b010, 32'h1000, 32'h0, 3, 1'b0, 1, 32'h1000, 4'hF, 32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF, 5);
        vt[8]  = mkv(1'b0, 3'b011, 32'h1000, 32'h0, 0, 1'b1, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vt[9]  = SPLIT_EN ?
                 mkv(1'b1, 3'b001, 32'h3003, 32'h0000_ABCD, 0, 1'b0, 2, 32'h3000, 4'h8, 32'hCD00_0000, 4'h1, 32'h0000_00AB, 32'h0, 3) :
                 mkv(1'b1, 3'b001, 32'h3003, 32'h0000_ABCD, 0, 1'b1, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vt[10] = SPLIT_EN ?
                 mkv(1'b0, 3'b010, 32'h4002, 32'h0, 0, 1'b0, 2, 32'h4000, 4'hC, 32'h0, 4'h3, 32'h0, 32'h7788_5566, 3) :
                 mkv(1'b0, 3'b010, 32'h4002, 32'h0, 0, 1'b1, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
        vt[11] = SPLIT_EN ?
                 mkv(1'b0, 3'b010, 32'h4002, 32'h0, 2, 1'b0, 2, 32'h4000, 4'hC, 32'h0, 4'h3, 32'h0, 32'h7788_5566, 7) :
                 mkv(1'b0, 3'b010, 32'h4002, 32'h0, 2, 1'b1, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1);

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_ctl", 32'({resp_valid, resp_err, xbus_req, xbus_we, xbus_be}), 32'h0);
        check("rst_addr", xbus_addr, 32'h0);
        check("rst_wdata", xbus_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            run_txn(vt[i].we, vt[i].f3, vt[i].a, vt[i].wd, vt[i].waits, r);
            check_common(tag, r, vt[i].err, vt[i].nb, vt[i].rd, vt[i].lat);
            if (vt[i].nb >= 1) begin
                check({tag, "_a0"}, r.ba[0], vt[i].a0);
                check({tag, "_be0"}, 32'(r.be[0]), 32'(vt[i].be0));
                if (vt[i].we) check({tag, "_wd0"}, r.bwd[0], vt[i].wd0);
            end
            if (vt[i].nb == 2) begin
                check({tag, "_a1"}, r.ba[1], vt[i].a0 + 32'h4);
                check({tag, "_be1"}, 32'(r.be[1]), 32'(vt[i].be1));
                if (vt[i].we) check({tag, "_wd1"}, r.bwd[1], vt[i].wd1);
            end
        end

        // Reset while beat 0 is waiting for ack, then a stray ack.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h1000;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_req_up", 32'(xbus_req), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_req_drop", 32'(xbus_req), 32'h0);
        check("mid_ready", 32'(req_ready), 32'h1);
        xbus_ack = 1'b1;
        xbus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        xbus_ack = 1'b0;
        check("mid_stray1", 32'({resp_valid, xbus_req}), 32'h0);
        @(negedge clk);
        check("mid_stray2", 32'({resp_valid, xbus_req, req_ready}), 32'h1);
        run_txn(vt[0].we, vt[0].f3, vt[0].a, vt[0].wd, vt[0].waits, r);
        check_common("mid_after", r, 1'b0, 1, 32'hDEAD_BEEF, 2);

        for (int i = 0; i < 150; i++) begin
            logic        we, uns, split, e_err;
            logic [1:0]  sz;
            logic [31:0] a, wd, e_rd, got, msk;
            int          s, o, w, e_nb, e_lat;
            string       tag;
            tag = $sformatf("rnd%0d", i);
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a   = 32'h7000 + 32'($urandom_range(0, 63));
            wd  = $urandom;
            w   = $urandom_range(0, 3);
            s   = 1 << sz;
            o   = int'(a % 4);
            split = (o + s) > 4;
            e_err = (sz == 2'b11) || (split && !SPLIT_EN);
            e_nb  = e_err ? 0 : (split ? 2 : 1);
            e_lat = e_err ? 1 : (split ? 3 + 2 * w : 2 + w);
            e_rd  = (e_err || we) ? 32'h0 : model_load(a, s, uns);
            run_txn(we, {uns, sz}, a, wd, w, r);
            check_common(tag, r, e_err, e_nb, e_rd, e_lat);
            for (int b = 0; b < e_nb; b++) begin
                check($sformatf("%s_a%0d", tag, b), r.ba[b], (a & 32'hFFFF_FFFC) + 32'(4 * b));
                check($sformatf("%s_be%0d", tag, b), 32'(r.be[b]), 32'(model_be(a, s, b)));
            end
            if (we && !e_err) begin
                got = model_load(a, s, 1'b1);
                msk = (s == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * s)) - 32'h1);
                check({tag, "_mem"}, got, wd & msk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
